// File: rtl/surf_rackctl_arbiter.sv
// surf_rackctl_arbiter: shares one surf_rackctl_phy between NREQ transaction requesters.
// Round-robin grant with one PHY transaction in flight. Mode 0/1 switches run as
// transaction-like operations. Errored transactions are retried, and a watchdog guards
// against a PHY that never completes.
//
// Ports:
//   sysclk_i, rst_n_i         clock, asynchronous active-low reset
//   req_i/addr_i/data_i       per-requester request level, {type,addr} slice, write data slice
//   ack_o/err_o               1-cycle completion pulses to the granted requester
//   resp_o                    read data of the last successful transaction
//   mode_req_i/mode_o         requested / committed rackctl mode
//   mode_ack_o/mode_err_o     mode switch finished / finished with error
//   busy_o                    arbiter not idle
//   txn_*_o, phy_mode_o       towards the PHY
//   txn_resp_i/done_i/err_i   from the PHY
module surf_rackctl_arbiter #(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned RETRIES   = 1,
  parameter int unsigned WDOG_BITS = 10
) (
  input  logic               sysclk_i,
  input  logic               rst_n_i,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ*24-1:0] addr_i,
  input  logic [NREQ*32-1:0] data_i,
  output logic [NREQ-1:0]    ack_o,
  output logic [NREQ-1:0]    err_o,
  output logic [31:0]        resp_o,
  input  logic               mode_req_i,
  output logic               mode_o,
  output logic               mode_ack_o,
  output logic               mode_err_o,
  output logic               busy_o,
  output logic [23:0]        txn_addr_o,
  output logic [31:0]        txn_data_o,
  output logic               txn_start_o,
  output logic               phy_mode_o,
  input  logic [31:0]        txn_resp_i,
  input  logic               txn_done_i,
  input  logic               txn_err_i
);

  localparam int unsigned IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned RCW = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;
  localparam logic [RCW-1:0] RetryMax = RCW'(RETRIES);
  localparam logic [IW-1:0]  LastReq  = IW'(NREQ - 1);

  typedef enum logic [2:0] {
    StIdle, StIssue, StWait, StGap, StResp, StModeIssue, StModeWait
  } state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       grant_q, grant_d, last_grant_q, last_grant_d;
  logic [RCW-1:0]      retry_q, retry_d;
  logic [WDOG_BITS-1:0] wdog_q, wdog_d;
  logic [23:0]         addr_q, addr_d;
  logic [31:0]         data_q, data_d, resp_q, resp_d;
  logic                ok_q, ok_d;
  logic                mode_q, mode_d, phy_mode_q, phy_mode_d, mode_tgt_q, mode_tgt_d;
  logic                mode_ack_q, mode_ack_d, mode_err_q, mode_err_d;
  logic [NREQ-1:0]     mask_q, mask_d;

  logic [NREQ-1:0]     eligible;
  logic                grant_found;
  logic [IW-1:0]       grant_idx;
  logic                wdog_sat;

  assign wdog_sat = &wdog_q;

  // Round-robin search starting just after the last served requester.
  always_comb begin : p_grant
    int unsigned cand;
    cand        = 0;
    eligible    = req_i & ~mask_q;
    grant_found = 1'b0;
    grant_idx   = last_grant_q;
    for (int i = 1; i <= NREQ; i++) begin
      cand = (32'(last_grant_q) + 32'(i)) % NREQ;
      if (!grant_found && eligible[IW'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = IW'(cand);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    retry_d      = retry_q;
    wdog_d       = wdog_q;
    addr_d       = addr_q;
    data_d       = data_q;
    resp_d       = resp_q;
    ok_d         = ok_q;
    mode_d       = mode_q;
    phy_mode_d   = phy_mode_q;
    mode_tgt_d   = mode_tgt_q;
    mode_ack_d   = 1'b0;
    mode_err_d   = 1'b0;
    mask_d       = '0;
    unique case (state_q)
      StIdle: begin
        if (mode_req_i != mode_q) begin
          mode_tgt_d = mode_req_i;
          state_d    = StModeIssue;
        end else if (grant_found) begin
          grant_d = grant_idx;
          addr_d  = addr_i[24*grant_idx +: 24];
          data_d  = data_i[32*grant_idx +: 32];
          retry_d = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        wdog_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        if (!wdog_sat) wdog_d = wdog_q + 1'b1;
        if (txn_done_i) begin
          resp_d  = txn_resp_i;
          ok_d    = 1'b1;
          state_d = StResp;
        end else if (txn_err_i) begin
          if (retry_q < RetryMax) begin
            retry_d = retry_q + 1'b1;
            state_d = StGap;
          end else begin
            ok_d    = 1'b0;
            state_d = StResp;
          end
        end else if (wdog_sat) begin
          ok_d    = 1'b0;
          state_d = StResp;
        end
      end
      StGap: state_d = StIssue;
      StResp: begin
        last_grant_d    = grant_q;
        // Requester drops req the cycle after ack/err; ignore it for one IDLE cycle.
        mask_d[grant_q] = 1'b1;
        state_d         = StIdle;
      end
      StModeIssue: begin
        phy_mode_d = mode_tgt_q;
        wdog_d     = '0;
        state_d    = StModeWait;
      end
      StModeWait: begin
        if (!wdog_sat) wdog_d = wdog_q + 1'b1;
        if (txn_done_i || txn_err_i || wdog_sat) begin
          // The PHY has switched regardless of the outcome, so commit anyway.
          mode_d     = phy_mode_q;
          mode_ack_d = 1'b1;
          mode_err_d = !txn_done_i;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= LastReq;
      retry_q      <= '0;
      wdog_q       <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      resp_q       <= '0;
      ok_q         <= 1'b0;
      mode_q       <= 1'b0;
      phy_mode_q   <= 1'b0;
      mode_tgt_q   <= 1'b0;
      mode_ack_q   <= 1'b0;
      mode_err_q   <= 1'b0;
      mask_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      retry_q      <= retry_d;
      wdog_q       <= wdog_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      resp_q       <= resp_d;
      ok_q         <= ok_d;
      mode_q       <= mode_d;
      phy_mode_q   <= phy_mode_d;
      mode_tgt_q   <= mode_tgt_d;
      mode_ack_q   <= mode_ack_d;
      mode_err_q   <= mode_err_d;
      mask_q       <= mask_d;
    end
  end

  always_comb begin
    ack_o = '0;
    err_o = '0;
    if (state_q == StResp) begin
      if (ok_q) ack_o[grant_q] = 1'b1;
      else      err_o[grant_q] = 1'b1;
    end
  end

  assign resp_o      = resp_q;
  assign mode_o      = mode_q;
  assign mode_ack_o  = mode_ack_q;
  assign mode_err_o  = mode_err_q;
  assign busy_o      = (state_q != StIdle);
  assign txn_addr_o  = addr_q;
  assign txn_data_o  = data_q;
  assign txn_start_o = (state_q == StIssue);
  assign phy_mode_o  = phy_mode_q;

endmodule

// File: tb/tb_surf_rackctl_arbiter.sv
// Directed bench for surf_rackctl_arbiter (NREQ=2, RETRIES=1, WDOG_BITS=10).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_surf_rackctl_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [47:0] addr;
  logic [63:0] data;
  logic [1:0]  ack, err;
  logic [31:0] resp;
  logic        mode_req, mode, mode_ack, mode_err, busy;
  logic [23:0] txn_addr;
  logic [31:0] txn_data;
  logic        txn_start, phy_mode;
  logic [31:0] txn_resp;
  logic        txn_done, txn_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int starts = 0;
  int last_start = 0;
  int prev_start = 0;

  always #5 clk = ~clk;

  surf_rackctl_arbiter #(.NREQ(2), .RETRIES(1), .WDOG_BITS(10)) dut (
    .sysclk_i   (clk),
    .rst_n_i    (rst_n),
    .req_i      (req),
    .addr_i     (addr),
    .data_i     (data),
    .ack_o      (ack),
    .err_o      (err),
    .resp_o     (resp),
    .mode_req_i (mode_req),
    .mode_o     (mode),
    .mode_ack_o (mode_ack),
    .mode_err_o (mode_err),
    .busy_o     (busy),
    .txn_addr_o (txn_addr),
    .txn_data_o (txn_data),
    .txn_start_o(txn_start),
    .phy_mode_o (phy_mode),
    .txn_resp_i (txn_resp),
    .txn_done_i (txn_done),
    .txn_err_i  (txn_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      if (txn_start) begin
        starts++;
        prev_start = last_start;
        last_start = cyc;
      end
    end
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (!txn_start && n < 50) begin
      run(1);
      n++;
    end
    check(tag, 32'(txn_start), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; req = '0; addr = '0; data = '0; mode_req = 1'b0;
    txn_resp = '0; txn_done = 1'b0; txn_err = 1'b0;
    run(2);
    // Reset values
    check("rst_busy", 32'(busy), 0);
    check("rst_start", 32'(txn_start), 0);
    check("rst_ackerr", 32'({ack, err}), 0);
    check("rst_mode", 32'({mode, mode_ack, mode_err, phy_mode}), 0);
    check("rst_addr", 32'(txn_addr), 0);
    check("rst_resp", resp, 0);
    rst_n = 1'b1;
    run(1);

    // Round robin, both requesting: 0,1,0,1
    req = 2'b11; addr = {24'h800200, 24'h000100}; data = {32'h22222222, 32'h11111111};
    for (int r = 0; r < 4; r++) begin
      starts = 0;
      wait_start("rr_start");
      check("rr_addr", 32'(txn_addr), (r % 2 == 0) ? 32'h000100 : 32'h800200);
      run(1);
      txn_done = 1'b1;
      run(1);
      check("rr_ack", 32'(ack), (r % 2 == 0) ? 32'd1 : 32'd2);
      check("rr_one_start", 32'(starts), 1);
      txn_done = 1'b0;
      req[r % 2] = 1'b0;
      run(1);
      req[r % 2] = (r < 2);
    end
    req = 2'b00;
    run(2);

    // Single read, done after 300 clocks
    starts = 0;
    req = 2'b01; addr[23:0] = 24'h800010; data[31:0] = 32'h0;
    run(1);
    check("t1_start", 32'(txn_start), 1);
    check("t1_addr", 32'(txn_addr), 32'h800010);
    run(299);
    check("t1_starts", 32'(starts), 1);
    check("t1_noack", 32'(ack), 0);
    txn_done = 1'b1; txn_resp = 32'hDEADBEEF;
    run(1);
    check("t1_ack", 32'(ack), 1);
    check("t1_resp", resp, 32'hDEADBEEF);
    txn_done = 1'b0; req = 2'b00;
    run(1);
    check("t1_idle", 32'({busy, ack}), 0);

    // Error then success on retry
    starts = 0;
    req = 2'b01; addr[23:0] = 24'h000300;
    wait_start("t3_start");
    run(1);
    txn_err = 1'b1;
    run(1);
    check("t3_gap", 32'({busy, txn_start}), 32'b10);
    txn_err = 1'b0;
    run(1);
    check("t3_restart", 32'(txn_start), 1);
    check("t3_spacing", 32'(last_start - prev_start), 3);
    run(1);
    txn_done = 1'b1; txn_resp = 32'hCAFEF00D;
    run(1);
    check("t3_ack", 32'({ack, err}), 32'b0100);
    check("t3_resp", resp, 32'hCAFEF00D);
    check("t3_starts", 32'(starts), 2);
    txn_done = 1'b0; req = 2'b00;
    run(1);

    // Error on both attempts: err_o, resp_o kept
    starts = 0;
    req = 2'b01; addr[23:0] = 24'h000400;
    wait_start("t3b_start");
    run(1);
    txn_err = 1'b1;
    run(1);
    txn_err = 1'b0;
    run(2);
    txn_err = 1'b1;
    run(1);
    check("t3b_err", 32'({ack, err}), 32'b0001);
    check("t3b_resp", resp, 32'hCAFEF00D);
    check("t3b_starts", 32'(starts), 2);
    txn_err = 1'b0; req = 2'b00;
    run(1);
    check("t3b_idle", 32'(busy), 0);

    // Silent PHY: watchdog fires 1025 clocks after the start pulse
    req = 2'b01; addr[23:0] = 24'h000500;
    wait_start("t4_start");
    begin
      int s;
      int n;
      s = cyc;
      n = 0;
      while (err == 2'b00 && n < 1200) begin
        run(1);
        n++;
      end
      check("t4_err", 32'(err), 1);
      check("t4_latency", 32'(cyc - s), 1025);
    end
    req = 2'b00;
    run(1);
    check("t4_idle", 32'(busy), 0);

    // Stray done/err in IDLE
    txn_done = 1'b1; txn_err = 1'b1;
    run(1);
    check("stray", 32'({busy, ack, err}), 0);
    txn_done = 1'b0; txn_err = 1'b0;
    run(1);

    // Mode switch 0->1 has priority over a pending request
    starts = 0;
    mode_req = 1'b1; req = 2'b01; addr[23:0] = 24'h000600;
    run(1);
    check("t5_missue", 32'({busy, txn_start, phy_mode}), 32'b100);
    run(1);
    check("t5_phymode", 32'({phy_mode, mode}), 32'b10);
    run(3);
    check("t5_nostart", 32'(starts), 0);
    txn_done = 1'b1;
    run(1);
    check("t5_mack", 32'({mode, mode_ack, mode_err}), 32'b110);
    txn_done = 1'b0;
    run(1);
    check("t5_txn", 32'({txn_start, mode_ack}), 32'b10);
    run(1);
    txn_done = 1'b1; txn_resp = 32'h12345678;
    run(1);
    check("t5_ack", 32'(ack), 1);
    txn_done = 1'b0; req = 2'b00;
    run(1);
    mode_req = 1'b0;
    run(2);
    check("t5_phymode0", 32'(phy_mode), 0);
    txn_err = 1'b1;
    run(1);
    check("t5_merr", 32'({mode, mode_ack, mode_err}), 32'b011);
    txn_err = 1'b0;
    run(1);
    check("t5_mdone", 32'({busy, mode_ack, mode_err}), 0);

    // Reset during WAIT
    req = 2'b01; addr[23:0] = 24'h800700; data[31:0] = 32'hA5A5A5A5;
    wait_start("t6_start");
    run(1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", 32'({busy, txn_start, phy_mode, mode}), 0);
    check("t6_rst_addr", 32'(txn_addr), 0);
    check("t6_rst_data", txn_data, 0);
    check("t6_rst_resp", resp, 0);
    req = 2'b00;
    #1;
    rst_n = 1'b1;
    txn_done = 1'b1;
    run(1);
    check("t6_late_done", 32'({busy, ack, err}), 0);
    txn_done = 1'b0;
    req = 2'b01; addr[23:0] = 24'h000800;
    wait_start("t6_restart");
    check("t6_addr", 32'(txn_addr), 32'h000800);
    run(1);
    txn_done = 1'b1; txn_resp = 32'h0BADF00D;
    run(1);
    check("t6_ack", 32'(ack), 1);
    check("t6_resp", resp, 32'h0BADF00D);
    txn_done = 1'b0; req = 2'b00;
    run(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
